// File: rtl/sd_arb_pkg.sv
// Shared types and widths for the SD sector arbiter.
package sd_arb_pkg;

    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_IDLE,
        S_GRANT,
        S_ISSUE,
        S_WAIT_START,
        S_XFER,
        S_DONE,
        S_FAIL
    } arb_state_e;

    localparam int SD_ADDR_W  = 32;
    localparam int SD_DATA_W  = 16;
    localparam int WORD_CNT_W = 9;

    // Width of the shared timeout counter: it must hold values up to the
    // larger of the two limits minus one.
    function automatic int timeout_width(input int busy_to, input int start_to);
        int m;
        m = (busy_to > start_to) ? busy_to : start_to;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sd_rr_pick2.sv
// Two-input round-robin picker; the pointer names the preferred port and
// moves to the port that was not granted whenever a grant is taken.
module sd_rr_pick2 (
    input  logic       clk,
    input  logic       srst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       valid,
    output logic       pick
);

    logic ptr_q, ptr_d;

    // Choose the pointed-to port on contention, otherwise the lone requester.
    always_comb begin
        valid = |req;
        pick  = (req == 2'b11) ? ptr_q : req[1];
        ptr_d = advance ? ~pick : ptr_q;
    end

    // Pointer register, port 0 preferred out of reset.
    always_ff @(posedge clk) begin
        if (srst) ptr_q <= 1'b0;
        else      ptr_q <= ptr_d;
    end

endmodule

// File: rtl/sd_sector_arbiter.sv
// Shares one SD SPI sector controller between a write requester (port 0)
// and a read-back requester (port 1), one sector command at a time.
module sd_sector_arbiter
    import sd_arb_pkg::*;
#(
    parameter int WORDS_PER_SECTOR = 256,
    parameter int BUSY_TIMEOUT     = 2_000_000,
    parameter int START_TIMEOUT    = 1024
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 init_end,
    input  logic                 req_0,
    input  logic                 req_1,
    input  logic                 we_0,
    input  logic                 we_1,
    input  logic [SD_ADDR_W-1:0] addr_0,
    input  logic [SD_ADDR_W-1:0] addr_1,
    input  logic [SD_DATA_W-1:0] wdata_0,
    input  logic [SD_DATA_W-1:0] wdata_1,
    output logic                 wreq_0,
    output logic                 wreq_1,
    output logic [SD_DATA_W-1:0] rdata,
    output logic                 rvalid_0,
    output logic                 rvalid_1,
    output logic                 gnt_0,
    output logic                 gnt_1,
    output logic                 done_0,
    output logic                 done_1,
    output logic                 err_0,
    output logic                 err_1,
    output logic                 sd_wr_req,
    output logic [SD_ADDR_W-1:0] sd_wr_addr,
    output logic [SD_DATA_W-1:0] sd_wr_data,
    input  logic                 sd_wr_data_req,
    input  logic                 sd_wr_busy,
    output logic                 sd_rd_req,
    output logic [SD_ADDR_W-1:0] sd_rd_addr,
    input  logic [SD_DATA_W-1:0] sd_rd_data,
    input  logic                 sd_rd_data_en,
    input  logic                 sd_rd_busy
);

    localparam int TO_W = timeout_width(BUSY_TIMEOUT, START_TIMEOUT);

    arb_state_e            state_q, state_d;
    logic                  sel_q, sel_d;      // granted port
    logic                  we_q, we_d;        // latched command direction
    logic [SD_ADDR_W-1:0]  addr_q, addr_d;    // latched sector address
    logic [WORD_CNT_W-1:0] cnt_q, cnt_d;      // words moved, saturating
    logic [TO_W-1:0]       to_q, to_d;        // start / busy timeout counter
    logic [1:0]            gnt_q, gnt_d;
    logic [1:0]            done_q, done_d;
    logic [1:0]            err_q, err_d;
    logic                  wr_req_q, wr_req_d;
    logic                  rd_req_q, rd_req_d;

    logic                  pick_valid, pick, advance;
    logic                  in_xfer, cmd_active, busy, strobe;
    logic [WORD_CNT_W-1:0] cnt_inc;

    assign advance = (state_q == S_IDLE) && init_end && pick_valid;

    sd_rr_pick2 u_pick (
        .clk     (sys_clk),
        .srst    (sys_rst),
        .req     ({req_1, req_0}),
        .advance (advance),
        .valid   (pick_valid),
        .pick    (pick)
    );

    assign in_xfer    = (state_q == S_XFER);
    assign cmd_active = (state_q == S_GRANT) || (state_q == S_ISSUE) ||
                        (state_q == S_WAIT_START) || in_xfer;
    assign busy       = we_q ? sd_wr_busy : sd_rd_busy;
    assign strobe     = in_xfer && (we_q ? sd_wr_data_req : sd_rd_data_en);
    assign cnt_inc    = (strobe && (cnt_q != '1)) ? cnt_q + WORD_CNT_W'(1) : cnt_q;

    // Data path: strobes and words only pass while the granted command is
    // transferring, so stray controller strobes never reach a requester.
    assign wreq_0     = in_xfer &&  we_q && !sel_q && sd_wr_data_req;
    assign wreq_1     = in_xfer &&  we_q &&  sel_q && sd_wr_data_req;
    assign rvalid_0   = in_xfer && !we_q && !sel_q && sd_rd_data_en;
    assign rvalid_1   = in_xfer && !we_q &&  sel_q && sd_rd_data_en;
    assign rdata      = (in_xfer && !we_q) ? sd_rd_data : '0;
    assign sd_wr_data = (in_xfer && we_q) ? (sel_q ? wdata_1 : wdata_0) : '0;
    assign sd_wr_addr = (cmd_active &&  we_q) ? addr_q : '0;
    assign sd_rd_addr = (cmd_active && !we_q) ? addr_q : '0;

    assign {gnt_1, gnt_0}   = gnt_q;
    assign {done_1, done_0} = done_q;
    assign {err_1, err_0}   = err_q;
    assign sd_wr_req        = wr_req_q;
    assign sd_rd_req        = rd_req_q;

    // Next-state and registered-output logic for the command sequencer.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        we_d     = we_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        to_d     = to_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        err_d    = '0;
        wr_req_d = 1'b0;
        rd_req_d = 1'b0;
        case (state_q)
            S_WAIT_INIT: if (init_end) state_d = S_IDLE;
            S_IDLE: begin
                if (!init_end) begin
                    state_d = S_WAIT_INIT;
                end else if (pick_valid) begin
                    sel_d   = pick;
                    we_d    = pick ? we_1 : we_0;
                    addr_d  = pick ? addr_1 : addr_0;
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                wr_req_d = we_q;
                rd_req_d = !we_q;
                state_d  = S_ISSUE;
            end
            S_ISSUE: begin
                to_d    = '0;
                state_d = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (busy) begin
                    to_d    = '0;
                    cnt_d   = '0;
                    state_d = S_XFER;
                end else if (to_q == TO_W'(START_TIMEOUT - 1)) begin
                    gnt_d   = '0;
                    err_d   = gnt_q;
                    state_d = S_FAIL;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_XFER: begin
                cnt_d = cnt_inc;
                if (!busy) begin
                    gnt_d = '0;
                    if (cnt_inc == WORD_CNT_W'(WORDS_PER_SECTOR)) begin
                        done_d  = gnt_q;
                        state_d = S_DONE;
                    end else begin
                        err_d   = gnt_q;
                        state_d = S_FAIL;
                    end
                end else if (to_q == TO_W'(BUSY_TIMEOUT - 1)) begin
                    gnt_d   = '0;
                    err_d   = gnt_q;
                    state_d = S_FAIL;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_DONE, S_FAIL: state_d = init_end ? S_IDLE : S_WAIT_INIT;
            default: state_d = S_WAIT_INIT;
        endcase
        // Card loss aborts an active command; the FAIL exit then waits for init.
        if (!init_end && cmd_active) begin
            gnt_d    = '0;
            done_d   = '0;
            err_d    = gnt_q;
            wr_req_d = 1'b0;
            rd_req_d = 1'b0;
            state_d  = S_FAIL;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= S_WAIT_INIT;
            sel_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            cnt_q    <= '0;
            to_q     <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            wr_req_q <= wr_req_d;
            rd_req_q <= rd_req_d;
        end
    end

endmodule

// File: doc/sd_sector_arbiter.md
Name: sd_sector_arbiter

Overview:
- Shares one SD-card SPI sector controller between two requesters: port 0 = UART receive-to-card write path, port 1 = card read-back path to the UART transmitter.
- Waits for card initialisation, then runs round-robin arbitration and issues one sector command at a time.
- Muxes 16-bit sector data between the granted requester and the controller, and reports done or timeout to that requester.
- Sits between the UART buffering logic and the SD controller, inside the UART-to-SD top level.

Parameters:
- WORDS_PER_SECTOR, 256: 16-bit words per 512-byte sector.
- BUSY_TIMEOUT, 2_000_000: sys_clk cycles allowed per command before abort (40 ms at 50 MHz).
- START_TIMEOUT, 1024: cycles allowed for the controller busy flag to rise after a request.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst  in  1  synchronous reset, active-high.
- init_end  in  1  SD controller initialisation complete.
- req_0, req_1  in  1 each  sector request, held high until done_x or err_x.
- we_0, we_1  in  1 each  1 = write sector, 0 = read sector; sampled at grant.
- addr_0, addr_1  in  32 each  sector address; sampled at grant.
- wdata_0, wdata_1  in  16 each  write word from requester.
- wreq_0, wreq_1  out  1 each  write-word strobe to the granted requester.
- rdata  out  16  read word, broadcast to both requesters.
- rvalid_0, rvalid_1  out  1 each  read-word valid, granted requester only.
- gnt_0, gnt_1  out  1 each  grant, one-hot or zero.
- done_0, done_1  out  1 each  one-cycle pulse on successful completion.
- err_0, err_1  out  1 each  one-cycle pulse on timeout or word-count error.
- sd_wr_req  out  1  write command to the controller.
- sd_wr_addr  out  32  write sector address.
- sd_wr_data  out  16  write word to the controller.
- sd_wr_data_req  in  1  controller requests the next write word.
- sd_wr_busy  in  1  controller write in progress.
- sd_rd_req  out  1  read command to the controller.
- sd_rd_addr  out  32  read sector address.
- sd_rd_data  in  16  read word from the controller.
- sd_rd_data_en  in  1  read word valid.
- sd_rd_busy  in  1  controller read in progress.

Behaviour:
- Reset: all outputs 0, state WAIT_INIT, round-robin pointer = port 0, counters 0. Reset mid-command drops every output at the next edge. Requesters must then re-request.
- WAIT_INIT: stay until init_end = 1, then go to IDLE.
- IDLE: pick among the asserted req_x using the pointer. The pointer names the preferred port and flips to the other port after every grant, so a port with a continuous request alternates with the other. If neither req_x is asserted, stay.
- Grant step: gnt_x = 1 in the cycle after selection. Latch we_x and addr_x into command registers. Go to ISSUE.
- ISSUE: assert sd_wr_req or sd_rd_req for exactly one cycle, with sd_*_addr held from the latched address for the whole command. Go to WAIT_START.
- WAIT_START: wait for sd_*_busy = 1. If START_TIMEOUT expires first, go to FAIL.
- XFER:
  - Write: wreq_x = sd_wr_data_req combinationally. sd_wr_data = wdata of the granted port, combinational mux.
  - Read: rvalid_x = sd_rd_data_en. rdata = sd_rd_data.
  - Count words, width 9 bits.
  - On busy falling: go to DONE if count == WORDS_PER_SECTOR, else go to FAIL.
  - If BUSY_TIMEOUT expires, go to FAIL.
- DONE / FAIL: pulse done_x or err_x for one cycle, deassert gnt_x in the same cycle, return to IDLE. Back-to-back grants are therefore at least 4 cycles apart.
- Requester dropping req_x mid-command: ignored; the command completes.
- Data beyond WORDS_PER_SECTOR: counted, suppresses the done pulse, and causes err_x at the end.
- init_end dropping while not in WAIT_INIT: treated as card loss. Go to FAIL if a command is active, then WAIT_INIT.
- sd_rd_data_en or sd_wr_data_req outside XFER: ignored, not forwarded.

Decomposition:
- Package sd_arb_pkg:
  - state encoding: WAIT_INIT, IDLE, GRANT, ISSUE, WAIT_START, XFER, DONE, FAIL;
  - SD_ADDR_W = 32, SD_DATA_W = 16;
  - timeout counter width, computed from BUSY_TIMEOUT.
- One natural sub-module, sd_rr_pick2: two-input round-robin picker with pointer update. Everything else stays in the top.

Test Plan:
- Init gate: req_0 = 1, init_end = 0 for 100 cycles -> no gnt_0, no sd_wr_req. Raise init_end -> gnt_0 two cycles later, then a one-cycle sd_wr_req with sd_wr_addr = addr_0 = 32'h0000_0800.
- Full write: the controller model pulses sd_wr_data_req 256 times with incrementing wdata_0 = 0..255 -> sd_wr_data matches each word; busy falls -> done_0 = 1 for one cycle; err_0 stays 0.
- Contention: req_0 and req_1 asserted continuously, we_1 = 0 -> grant order 0, 1, 0, 1. The read phase produces exactly 256 rvalid_1 pulses and rvalid_0 stays 0 throughout.
- Short sector: the controller supplies 255 words, then busy falls -> err_x pulses, done_x stays 0, and the next request is granted normally.
- Timeouts: busy never rises -> err after START_TIMEOUT + 3 cycles. With BUSY_TIMEOUT = 500, busy stuck high -> err at cycle 500 of XFER.
- Reset mid-XFER: sys_rst = 1 for one cycle at word 100 -> all outputs 0 next edge, state WAIT_INIT, pointer at port 0.
